// File: rtl/name_scroller_if.sv
// Control/display bundle for name_scroller: scroll controls, message write port,
// and the registered segment/offset/wrap outputs.
interface name_scroller_if #(
   parameter int DIGITS  = 4,
   parameter int MSG_LEN = 8
) ();
   localparam int AW = $clog2(MSG_LEN);

   logic                  en;
   logic                  dir;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [3:0]            wr_data;
   logic [7*DIGITS-1:0]   hex;
   logic [AW-1:0]         offset;
   logic                  wrap;

   modport master (output en, dir, wr_en, wr_addr, wr_data,
                   input  hex, offset, wrap);
   modport slave  (input  en, dir, wr_en, wr_addr, wr_data,
                   output hex, offset, wrap);
endinterface

// File: rtl/name_scroller.sv
// Scrolling message driver: writable 4-bit message memory shown through a
// DIGITS-wide window on seven-segment digits, rotated left/right on a tick.
module name_scroller_seg #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] code,
   output logic [6:0] seg
);
   logic [6:0] seg_hi;

   always_comb begin
      seg_hi = 7'h00;
      case (code)
         4'd0:    seg_hi = 7'h3F;
         4'd1:    seg_hi = 7'h06;
         4'd2:    seg_hi = 7'h5B;
         4'd3:    seg_hi = 7'h4F;
         4'd4:    seg_hi = 7'h66;
         4'd5:    seg_hi = 7'h6D;
         4'd6:    seg_hi = 7'h7D;
         4'd7:    seg_hi = 7'h07;
         4'd8:    seg_hi = 7'h7F;
         4'd9:    seg_hi = 7'h6F;
         4'd10:   seg_hi = 7'h77;
         4'd11:   seg_hi = 7'h7C;
         4'd12:   seg_hi = 7'h39;
         4'd13:   seg_hi = 7'h5E;
         4'd14:   seg_hi = 7'h79;
         default: seg_hi = 7'h00;
      endcase
   end

   assign seg = seg_hi ^ {7{SEG_ACTIVE_LOW}};
endmodule

module name_scroller #(
   parameter int DIGITS         = 4,
   parameter int MSG_LEN        = 8,
   parameter int TICK_DIV       = 25000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic           clk,
   input  logic           resetn,
   name_scroller_if.slave bus
);
   localparam int            AW    = $clog2(MSG_LEN);
   localparam int            CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [AW:0]   LEN_W = (AW+1)'(MSG_LEN);
   localparam logic [AW-1:0] LAST  = AW'(MSG_LEN - 1);
   localparam logic [CW-1:0] CMAX  = CW'(TICK_DIV - 1);

   logic [MSG_LEN-1:0][3:0] msg_q, msg_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [AW-1:0]           off_q, off_d;
   logic                    wrap_q, wrap_d;
   logic [7*DIGITS-1:0]     hex_q, hex_d;
   logic                    step;

   logic [DIGITS-1:0][3:0]  code;
   logic [DIGITS-1:0][6:0]  seg;

   // Lane offsets are reduced mod MSG_LEN at elaboration, so offset+inc stays
   // below 2*MSG_LEN and one conditional subtract is enough even when DIGITS > MSG_LEN.
   for (genvar g = 0; g < DIGITS; g++) begin : g_lane
      localparam logic [AW:0] INC = (AW+1)'(g % MSG_LEN);
      logic [AW:0] sum, red;

      assign sum = {1'b0, off_q} + INC;
      assign red = (sum >= LEN_W) ? (sum - LEN_W) : sum;
      assign code[g] = msg_q[red[AW-1:0]];

      name_scroller_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
         .code (code[g]),
         .seg  (seg[g])
      );
   end

   always_comb begin
      msg_d  = msg_q;
      cnt_d  = cnt_q;
      off_d  = off_q;
      wrap_d = 1'b0;
      hex_d  = '0;
      step   = bus.en && (cnt_q == CMAX);

      if (bus.wr_en && ({1'b0, bus.wr_addr} < LEN_W))
         msg_d[bus.wr_addr] = bus.wr_data;

      if (bus.en)
         cnt_d = step ? '0 : cnt_q + 1'b1;

      if (step) begin
         if (!bus.dir) begin
            wrap_d = (off_q == LAST);
            off_d  = wrap_d ? '0 : off_q + 1'b1;
         end else begin
            wrap_d = (off_q == '0);
            off_d  = wrap_d ? LAST : off_q - 1'b1;
         end
      end

      // Digit 0 is the leftmost and occupies the top seven bits.
      for (int i = 0; i < DIGITS; i++)
         hex_d[7*(DIGITS-1-i) +: 7] = seg[i];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         msg_q  <= {MSG_LEN{4'hF}};
         cnt_q  <= '0;
         off_q  <= '0;
         wrap_q <= 1'b0;
         hex_q  <= {(7*DIGITS){SEG_ACTIVE_LOW}};
      end else begin
         msg_q  <= msg_d;
         cnt_q  <= cnt_d;
         off_q  <= off_d;
         wrap_q <= wrap_d;
         hex_q  <= hex_d;
      end
   end

   assign bus.hex    = hex_q;
   assign bus.offset = off_q;
   assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_name_scroller.sv
// Two scroller configurations driven by shared directed + random stimulus,
// each compared every cycle against a queue-free arithmetic reference model.
module tb_name_scroller;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   name_scroller_if #(.DIGITS(4), .MSG_LEN(6)) ifa ();
   name_scroller_if #(.DIGITS(8), .MSG_LEN(5)) ifb ();

   name_scroller #(.DIGITS(4), .MSG_LEN(6), .TICK_DIV(3), .SEG_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .resetn(resetn), .bus(ifa));
   name_scroller #(.DIGITS(8), .MSG_LEN(5), .TICK_DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .bus(ifb));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model, per instance k
   int        p_dig [2] = '{4, 8};
   int        p_len [2] = '{6, 5};
   int        p_td  [2] = '{3, 1};
   bit        p_al  [2] = '{1'b1, 1'b0};
   bit [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00};
   int          m_msg  [2][16];
   int          m_cnt  [2];
   int          m_off  [2];
   bit          m_wrap [2];
   logic [63:0] m_hex  [2];

   logic       s_en, s_dir, s_wr;
   logic [2:0] s_addr;
   logic [3:0] s_data;

   function automatic logic [63:0] view(int k);
      logic [63:0] v = '0;
      for (int i = 0; i < p_dig[k]; i++) begin
         bit [6:0] s = seg_tbl[m_msg[k][(m_off[k] + i) % p_len[k]]];
         if (p_al[k]) s = ~s;
         v |= 64'(s) << (7 * (p_dig[k] - 1 - i));
      end
      return v;
   endfunction

   task automatic model_edge(int k);
      if (!resetn) begin
         for (int j = 0; j < 16; j++) m_msg[k][j] = 15;
         m_cnt[k] = 0; m_off[k] = 0; m_wrap[k] = 1'b0;
         m_hex[k] = p_al[k] ? ((64'd1 << (7 * p_dig[k])) - 1) : 64'd0;
      end else begin
         m_hex[k]  = view(k);
         m_wrap[k] = 1'b0;
         if (s_wr && int'(s_addr) < p_len[k]) m_msg[k][s_addr] = int'(s_data);
         if (s_en) begin
            if (m_cnt[k] == p_td[k] - 1) begin
               m_cnt[k] = 0;
               if (!s_dir) begin
                  m_wrap[k] = (m_off[k] == p_len[k] - 1);
                  m_off[k]  = (m_off[k] + 1) % p_len[k];
               end else begin
                  m_wrap[k] = (m_off[k] == 0);
                  m_off[k]  = (m_off[k] + p_len[k] - 1) % p_len[k];
               end
            end else m_cnt[k]++;
         end
      end
   endtask

   task automatic drive(input logic en, input logic dir, input logic wr,
                        input logic [2:0] addr, input logic [3:0] data);
      s_en = en; s_dir = dir; s_wr = wr; s_addr = addr; s_data = data;
      ifa.en = en; ifa.dir = dir; ifa.wr_en = wr; ifa.wr_addr = addr; ifa.wr_data = data;
      ifb.en = en; ifb.dir = dir; ifb.wr_en = wr; ifb.wr_addr = addr; ifb.wr_data = data;
   endtask

   task automatic tick(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_edge(0);
         model_edge(1);
         #1;
         chk("a_off",  64'(ifa.offset), 64'(m_off[0]));
         chk("a_wrap", 64'(ifa.wrap),   64'(m_wrap[0]));
         chk("a_hex",  64'(ifa.hex),    m_hex[0]);
         chk("b_off",  64'(ifb.offset), 64'(m_off[1]));
         chk("b_wrap", 64'(ifb.wrap),   64'(m_wrap[1]));
         chk("b_hex",  64'(ifb.hex),    m_hex[1]);
      end
   endtask

   int codes [6] = '{13, 14, 10, 13, 15, 1};

   initial begin
      resetn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(2);
      chk("rst_hex", 64'(ifa.hex), 64'h0FFFFFFF);
      chk("rst_off", 64'(ifa.offset), 64'd0);
      resetn = 1'b1;
      tick(10);
      chk("idle_hex", 64'(ifa.hex), 64'h0FFFFFFF);

      // out-of-range slot leaves memory blank
      drive(1'b0, 1'b0, 1'b1, 3'd7, 4'd0);
      tick(1);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(2);
      chk("oob_wr", 64'(ifa.hex), 64'h0FFFFFFF);

      for (int s = 0; s < 6; s++) begin
         drive(1'b0, 1'b0, 1'b1, 3'(s), 4'(codes[s]));
         tick(1);
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(2);
      chk("dead", 64'(ifa.hex), 64'({7'h21, 7'h06, 7'h08, 7'h21}));

      drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(13);
      chk("off4", 64'(ifa.offset), 64'd4);
      chk("win4", 64'(ifa.hex), 64'({7'h7F, 7'h79, 7'h21, 7'h06}));
      tick(5);
      chk("lwrap_off", 64'(ifa.offset), 64'd0);
      chk("lwrap",     64'(ifa.wrap),   64'd1);

      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      tick(3);
      chk("rwrap_off", 64'(ifa.offset), 64'd5);
      chk("rwrap",     64'(ifa.wrap),   64'd1);
      tick(1);
      drive(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
      tick(7);
      chk("frz_off", 64'(ifa.offset), 64'd5);
      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      tick(1);
      chk("held1", 64'(ifa.offset), 64'd5);
      tick(1);
      chk("held2", 64'(ifa.offset), 64'd4);

      drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(8);
      drive(1'b1, 1'b0, 1'b1, 3'd1, 4'd0);
      tick(1);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
      tick(1);
      chk("ws_off", 64'(ifa.offset), 64'd1);
      chk("ws_dig0", 64'(ifa.hex[27:21]), 64'h40);

      resetn = 1'b0;
      tick(1);
      chk("mid_rst_off", 64'(ifa.offset), 64'd0);
      chk("mid_rst_hex", 64'(ifa.hex), 64'h0FFFFFFF);
      resetn = 1'b1;

      begin
         logic d = 1'b0;
         for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) d = ~d;
            resetn = ($urandom_range(59) != 0);
            drive($urandom_range(3) != 0, d, $urandom_range(2) == 0,
                  3'($urandom_range(7)), 4'($urandom_range(15)));
            tick(1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
